// File: rtl/mips_cpu_mult_div.sv
// rtl/mips_cpu_mult_div.sv - iterative MIPS multiply/divide unit with HI/LO registers
//
// Executes MULT, MULTU, DIV, DIVU (multi-cycle) and MTHI, MTLO, MFHI, MFLO
// (single-cycle) for the execute stage. The pipeline stalls on busy.
//
// Ports:
//   clk     in   1  clock, rising edge
//   rst_n   in   1  asynchronous active-low reset
//   start   in   1  issue request, sampled only while busy=0
//   op      in   3  011 MULT, 001 MULTU, 010 DIV, 000 DIVU,
//                   100 MTHI, 101 MTLO, 110 MFHI, 111 MFLO
//   a       in  32  rs operand (multiplicand / dividend / MTHI-MTLO source)
//   b       in  32  rt operand (multiplier / divisor)
//   busy    out  1  multiply or divide in flight
//   done    out  1  one-cycle pulse after HI/LO were written by mul/div
//   result  out 32  combinational MFHI/MFLO read port (0 for other ops)
//   hi      out 32  architectural HI
//   lo      out 32  architectural LO
//
// Build option: MIPS_CPU_MULT_DIV_FASTMUL_EN selects a single-cycle array
// multiply for MULT/MULTU; divides keep the 33-cycle iterative path.

module mips_cpu_mult_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;
  localparam logic [2:0] OP_MFHI = 3'b110;
  localparam logic [2:0] OP_MFLO = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [63:0] r_acc;    // multiply: {partial product, multiplier}; divide: {remainder, quotient}
  logic [31:0] r_opnd;   // multiplicand magnitude or divisor magnitude
  logic [5:0]  r_cnt;
  logic        r_mul;
  logic        r_neg_a;  // operand signs, only ever set for signed ops
  logic        r_neg_b;
  logic        r_dz;     // divide by zero
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // op[2]=0 selects the mul/div family; op[0] picks multiply, op[1] signed.
  logic        w_muldiv;
  logic        w_signed;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;

  assign w_muldiv = ~op[2];
  assign w_signed = op[1];
  assign w_a_mag  = (w_signed && a[31]) ? (~a + 32'd1) : a;
  assign w_b_mag  = (w_signed && b[31]) ? (~b + 32'd1) : b;

  // Shift-add multiply step: add the multiplicand into the upper half when
  // the current multiplier bit is set, then shift the whole accumulator right.
  // The 33-bit sum keeps the carry, which becomes the new top bit.
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_step;

  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_step = {w_mul_sum, r_acc[31:1]};

  // Restoring divide step: the trial remainder is the current remainder
  // shifted left with the next dividend bit, i.e. r_acc[63:31] (33 bits).
  // When it is >= divisor the difference always fits in 32 bits.
  logic        w_div_ge;
  logic [31:0] w_div_diff;
  logic [63:0] w_div_step;

  assign w_div_ge   = (r_acc[63:31] >= {1'b0, r_opnd});
  assign w_div_diff = r_acc[62:31] - r_opnd;
  assign w_div_step = w_div_ge ? {w_div_diff, r_acc[30:0], 1'b1}
                               : {r_acc[62:0], 1'b0};

`ifdef MIPS_CPU_MULT_DIV_FASTMUL_EN
  logic [63:0] w_fast_prod;
  assign w_fast_prod = 64'(w_a_mag) * 64'(w_b_mag);
`endif

  // Sign correction applied in FIX.
  logic        w_sign_diff;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;

  assign w_sign_diff = r_neg_a ^ r_neg_b;
  assign w_prod_fix  = w_sign_diff ? (~r_acc + 64'd1) : r_acc;
  assign w_quot_fix  = w_sign_diff ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
  // Remainder follows the dividend; for a divide by zero this restores the
  // raw dividend, since the remainder magnitude is then |a|.
  assign w_rem_fix   = r_neg_a ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && w_muldiv) begin
`ifdef MIPS_CPU_MULT_DIV_FASTMUL_EN
          w_next = op[0] ? S_FIX : S_CALC;
`else
          w_next = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (r_cnt == 6'd31) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= 64'd0;
      r_opnd  <= 32'd0;
      r_cnt   <= 6'd0;
      r_mul   <= 1'b0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_dz    <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (op == OP_MTHI) begin
              r_hi <= a;
            end else if (op == OP_MTLO) begin
              r_lo <= a;
            end else if (w_muldiv) begin
              r_mul   <= op[0];
              r_neg_a <= w_signed & a[31];
              r_neg_b <= w_signed & b[31];
              r_dz    <= ~op[0] & (b == 32'd0);
              r_cnt   <= 6'd0;
              if (op[0]) begin
                r_opnd <= w_a_mag;
`ifdef MIPS_CPU_MULT_DIV_FASTMUL_EN
                r_acc  <= w_fast_prod;
`else
                r_acc  <= {32'd0, w_b_mag};
`endif
              end else begin
                r_opnd <= w_b_mag;
                r_acc  <= {32'd0, w_a_mag};
              end
            end
          end
        end
        S_CALC: begin
          r_acc <= r_mul ? w_mul_step : w_div_step;
          r_cnt <= r_cnt + 6'd1;
        end
        S_FIX: begin
          if (r_mul) begin
            r_hi <= w_prod_fix[63:32];
            r_lo <= w_prod_fix[31:0];
          end else begin
            r_hi <= w_rem_fix;
            r_lo <= r_dz ? 32'hFFFF_FFFF : w_quot_fix;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign hi     = r_hi;
  assign lo     = r_lo;
  assign result = (op == OP_MFHI) ? r_hi :
                  (op == OP_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mips_cpu_mult_div.sv
// tb/tb_mips_cpu_mult_div.sv - randomized self-checking bench for mips_cpu_mult_div

module tb_mips_cpu_mult_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;

  mips_cpu_mult_div dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural result {hi, lo} of a multiply/divide, from plain arithmetic.
  function automatic logic [63:0] ref_muldiv(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx;
    longint      sy;
    int          qs;
    int          rs;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'b011: r = 64'(sx * sy);
      3'b001: r = {32'd0, x} * {32'd0, y};
      3'b010: begin
        if (y == 32'd0) begin
          r = {x, 32'hFFFF_FFFF};
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          r = {32'd0, 32'h8000_0000};
        end else begin
          qs = $signed(x) / $signed(y);
          rs = $signed(x) % $signed(y);
          r = {32'(rs), 32'(qs)};
        end
      end
      default: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else            r = {x % y, x / y};
      end
    endcase
    return r;
  endfunction

  task automatic do_muldiv(input string tag, input logic [2:0] o, input logic [31:0] x,
                           input logic [31:0] y, input bit junk, input logic [2:0] jop,
                           input logic [31:0] ja);
    logic [63:0] e;
    int          cnt;
    int          exp_busy;
    e = ref_muldiv(o, x, y);
`ifdef MIPS_CPU_MULT_DIV_FASTMUL_EN
    exp_busy = o[0] ? 1 : 33;
`else
    exp_busy = 33;
`endif
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (junk && cnt == 1) begin
        op = jop; a = ja; b = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(cnt), 64'(exp_busy));
    chk({tag, "_done"}, 64'(done), 64'd1);
    m_hi = e[63:32];
    m_lo = e[31:0];
    chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  // Single-cycle ops (MTHI/MTLO/MFHI/MFLO) followed by a read-back through result.
  task automatic do_single(input string tag, input logic [2:0] o, input logic [31:0] x);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = $urandom;
    @(negedge clk);
    start = 1'b0;
    if (o == 3'b100) m_hi = x;
    if (o == 3'b101) m_lo = x;
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    op = 3'b110;
    #1 chk({tag, "_mfhi"}, 64'(result), 64'(m_hi));
    op = 3'b111;
    #1 chk({tag, "_mflo"}, 64'(result), 64'(m_lo));
    op = 3'b011;
    #1 chk({tag, "_result_zero"}, 64'(result), 64'd0);
  endtask

  task automatic reset_mid_div();
    @(negedge clk);
    start = 1'b1; op = 3'b010; a = $urandom; b = $urandom_range(1, 1000);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("rst_mid_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_hi", 64'(hi), 64'(m_hi));
    chk("rst_mid_lo", 64'(lo), 64'(m_lo));
    chk("rst_mid_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) begin
        chk("rst_mid_no_done", 64'({busy, done}), 64'd0);
        break;
      end
    end
    chk("rst_mid_hi_after", 64'(hi), 64'd0);
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    int          sel;

    rst_n = 1'b1; start = 1'b0; op = 3'b000; a = 32'd0; b = 32'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_single("mthi", 3'b100, 32'h1234_5678);
    do_single("mtlo", 3'b101, 32'h9ABC_DEF0);
    do_muldiv("mult_neg3x7", 3'b011, 32'hFFFF_FFFD, 32'd7, 1'b0, 3'b000, 32'd0);
    chk("mult_neg3x7_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    chk("mult_neg3x7_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFEB);
    do_muldiv("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3'b000, 32'd0);
    do_muldiv("div_neg7_2", 3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0, 3'b000, 32'd0);
    do_muldiv("div_min_m1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 3'b000, 32'd0);
    do_muldiv("divu_zero", 3'b000, 32'h55, 32'd0, 1'b1, 3'b100, 32'hDEAD);
    do_muldiv("div_neg_zero", 3'b010, 32'hFFFF_FF00, 32'd0, 1'b0, 3'b000, 32'd0);

    for (int i = 0; i < 24; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      sel  = $urandom_range(0, 7);
      case (sel)
        0:       r_b = 32'd0;
        1, 2:    r_b = $urandom_range(1, 20);
        3:       r_b = 32'hFFFF_FFFF;
        default: r_b = $urandom;
      endcase
      if (!r_op[2]) begin
        do_muldiv($sformatf("rnd%0d_op%0d", i, r_op), r_op, r_a, r_b,
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
      end else begin
        do_single($sformatf("rnd%0d_op%0d", i, r_op), r_op, r_a);
      end
    end

    reset_mid_div();
    do_muldiv("post_reset_mult", 3'b011, 32'h8000_0000, 32'h8000_0000, 1'b0, 3'b000, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
